// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide unit: md_op encodings, the
//   op-field width, the control FSM state type and a decode helper.
// ---------------------------------------------------------------------------
package md_pkg;

   localparam int MD_OP_W = 3;

   typedef enum logic [MD_OP_W-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_NOP6  = 3'd6,
      MD_NOP7  = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // True for the multi-cycle ops that go through the RUN state.
   function automatic logic is_md_arith(md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_div32.sv
// ---------------------------------------------------------------------------
// md_div32
//   Combinational 32-bit divider, signed or unsigned.
//   Ports:
//     a         in  32  dividend
//     b         in  32  divisor
//     is_signed in  1   1 = div (signed), 0 = divu
//     quo       out 32  quotient (goes to LO)
//     rem       out 32  remainder (goes to HI)
//   Divide by zero yields quo = all ones, rem = dividend. The signed
//   overflow case 0x8000_0000 / -1 yields quo = 0x8000_0000, rem = 0.
// ---------------------------------------------------------------------------
module md_div32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        is_signed,
   output logic [31:0] quo,
   output logic [31:0] rem
);

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves
      // a value unassigned and no latch is inferred.
      quo = '0;
      rem = '0;
      if (b == 32'd0) begin
         quo = 32'hFFFF_FFFF;
         rem = a;
      end else if (is_signed) begin
         if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
         end else begin
            // Signed / and % truncate toward zero; remainder takes the dividend's sign.
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
         end
      end else begin
         quo = a / b;
         rem = a % b;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//   The result is computed at the accept edge into pending registers; md_busy
//   then stays high for exactly MULT_CYCLES / DIV_CYCLES cycles and the pending
//   value is committed to hi_q/lo_q on the edge that drops md_busy.
//   Ports:
//     clk      in  1   system clock, rising edge
//     rst_n    in  1   asynchronous active-low reset
//     md_start in  1   request qualifier, accepted when !md_busy
//     md_op    in  3   operation (md_op_e)
//     md_a     in  32  rs operand
//     md_b     in  32  rt operand
//     md_busy  out 1   operation in flight
//     hi_q     out 32  committed HI
//     lo_q     out 32  committed LO
// ---------------------------------------------------------------------------
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               md_start,
   input  logic [MD_OP_W-1:0] md_op,
   input  logic [31:0]        md_a,
   input  logic [31:0]        md_b,
   output logic               md_busy,
   output logic [31:0]        hi_q,
   output logic [31:0]        lo_q
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   md_op_e           op;
   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      pend_hi_q, pend_lo_q;
   logic             accept;
   logic [63:0]      prod_s, prod_u;
   logic [31:0]      div_quo, div_rem;

   assign op      = md_op_e'(md_op);
   assign accept  = md_start && (state_q == MD_IDLE);
   assign md_busy = (state_q == MD_RUN);

   assign prod_s = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
   assign prod_u = {32'd0, md_a} * {32'd0, md_b};

   md_div32 u_div (
      .a         (md_a),
      .b         (md_b),
      .is_signed (op == MD_DIV),
      .quo       (div_quo),
      .rem       (div_rem)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (accept && is_md_arith(op)) state_d = MD_RUN;
         MD_RUN:  if (cnt_q == '0)               state_d = MD_IDLE;
         default:                                state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MD_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the pending result is cleared too, so a reset mid-operation can
         // never leave a stale value behind to be committed later.
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (state_q == MD_IDLE) begin
         if (accept) begin
            case (op)
               MD_MULT: begin
                  {pend_hi_q, pend_lo_q} <= prod_s;
                  cnt_q                  <= CNT_W'(MULT_CYCLES - 1);
               end
               MD_MULTU: begin
                  {pend_hi_q, pend_lo_q} <= prod_u;
                  cnt_q                  <= CNT_W'(MULT_CYCLES - 1);
               end
               MD_DIV, MD_DIVU: begin
                  pend_hi_q <= div_rem;
                  pend_lo_q <= div_quo;
                  cnt_q     <= CNT_W'(DIV_CYCLES - 1);
               end
               MD_MTHI: hi_q <= md_a;
               MD_MTLO: lo_q <= md_a;
               default: ;
            endcase
         end
      end else if (cnt_q == '0) begin
         hi_q <= pend_hi_q;
         lo_q <= pend_lo_q;
      end else begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule
